// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port (ICache/DCache) memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 128;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bundles the ICache, DCache and memory handshakes seen by the arbiter.
interface mem_arb_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
);

    logic              ic_req_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              ic_ready_o;
    logic [LINE_W-1:0] ic_data_o;

    logic              dc_req_i;
    logic              dc_we_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [LINE_W-1:0] dc_wdata_i;
    logic              dc_ready_o;
    logic [LINE_W-1:0] dc_data_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [LINE_W-1:0] mem_data_i;

    // The environment (caches plus memory) drives requests and memory responses.
    modport master (
        output ic_req_i, ic_addr_i,
        output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
        output mem_ready_i, mem_data_i,
        input  ic_ready_o, ic_data_o, dc_ready_o, dc_data_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  ic_req_i, ic_addr_i,
        input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
        input  mem_ready_i, mem_data_i,
        output ic_ready_o, ic_data_o, dc_ready_o, dc_data_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_arb_slot.sv
// One-deep request capture slot: holds a port's request until the arbiter completes it.
module mem_arb_slot import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              clr_i,
    output logic              pending_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LINE_W-1:0] wdata_o
);

    logic              pending_q, pending_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    // A request arriving on the completion edge refills the slot, so set beats clear.
    always_comb begin
        pending_d = pending_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (clr_i) begin
            pending_d = 1'b0;
        end
        if (req_i && (!pending_q || clr_i)) begin
            pending_d = 1'b1;
            we_d      = we_i;
            addr_d    = addr_i;
            wdata_d   = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign pending_o = pending_q;
    assign we_o      = we_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between ICache refills and DCache
// reads/write-backs, with a single outstanding memory transaction.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q, last_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              ic_ready_q, ic_ready_d;
    logic              dc_ready_q, dc_ready_d;
    logic [LINE_W-1:0] ic_data_q, ic_data_d;
    logic [LINE_W-1:0] dc_data_q, dc_data_d;

    logic              ic_pend, dc_pend;
    logic              ic_we, dc_we;
    logic [ADDR_W-1:0] ic_addr, dc_addr;
    logic [LINE_W-1:0] ic_wdata, dc_wdata;
    logic              ic_clr, dc_clr;
    logic              grant_dc;

    mem_arb_slot #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_ic_slot (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.ic_req_i),
        .we_i      (1'b0),
        .addr_i    (bus.ic_addr_i),
        .wdata_i   ('0),
        .clr_i     (ic_clr),
        .pending_o (ic_pend),
        .we_o      (ic_we),
        .addr_o    (ic_addr),
        .wdata_o   (ic_wdata)
    );

    mem_arb_slot #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_dc_slot (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.dc_req_i),
        .we_i      (bus.dc_we_i),
        .addr_i    (bus.dc_addr_i),
        .wdata_i   (bus.dc_wdata_i),
        .clr_i     (dc_clr),
        .pending_o (dc_pend),
        .we_o      (dc_we),
        .addr_o    (dc_addr),
        .wdata_o   (dc_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ic_pend || dc_pend)  state_d = ST_BUSY;
            ST_BUSY: if (bus.mem_ready_i)     state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // DCache wins a tie only when the ICache was the last port served.
    always_comb begin
        grant_dc    = dc_pend && (!ic_pend || (last_q == OWN_IC));
        owner_d     = owner_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_ready_d  = 1'b0;
        dc_ready_d  = 1'b0;
        ic_data_d   = ic_data_q;
        dc_data_d   = dc_data_q;
        ic_clr      = 1'b0;
        dc_clr      = 1'b0;

        if ((state_q == ST_IDLE) && (ic_pend || dc_pend)) begin
            owner_d     = grant_dc ? OWN_DC : OWN_IC;
            mem_req_d   = 1'b1;
            mem_we_d    = grant_dc ? dc_we    : ic_we;
            mem_addr_d  = grant_dc ? dc_addr  : ic_addr;
            mem_wdata_d = grant_dc ? dc_wdata : ic_wdata;
        end

        if ((state_q == ST_BUSY) && bus.mem_ready_i) begin
            mem_req_d = 1'b0;
            last_d    = owner_q;
            if (owner_q == OWN_IC) begin
                ic_ready_d = 1'b1;
                ic_data_d  = bus.mem_data_i;
                ic_clr     = 1'b1;
            end else begin
                dc_ready_d = 1'b1;
                dc_clr     = 1'b1;
                if (!mem_we_q) begin
                    dc_data_d = bus.mem_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_IC;
            last_q      <= OWN_DC;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
            ic_data_q   <= '0;
            dc_data_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_ready_q  <= ic_ready_d;
            dc_ready_q  <= dc_ready_d;
            ic_data_q   <= ic_data_d;
            dc_data_q   <= dc_data_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.ic_ready_o  = ic_ready_q;
    assign bus.ic_data_o   = ic_data_q;
    assign bus.dc_ready_o  = dc_ready_q;
    assign bus.dc_data_o   = dc_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the slot/round-robin rules.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    typedef logic [LW-1:0] line_t;
    typedef logic [AW-1:0] addr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int    port;
        addr_t addr;
        logic  we;
        line_t wdata;
    } txn_t;

    typedef struct {
        int port;
        int cyc;
    } resp_t;

    txn_t  mem_q[$];
    resp_t resp_q[$];

    // Reference model state: per-port request slot, one in-flight transaction, last served port.
    bit    m_pend[2];
    addr_t m_addr[2];
    logic  m_we[2];
    line_t m_wdata[2];
    line_t m_data[2];
    bit    m_busy;
    int    m_owner;
    int    m_last;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    int cyc      = 0;
    bit prev_req = 1'b0;

    task automatic check(input string name, input line_t act, input line_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelStep();
        int pick;
        int served;
        cyc++;
        if (rst) begin
            m_pend[0] = 1'b0;
            m_pend[1] = 1'b0;
            m_busy    = 1'b0;
            m_owner   = 0;
            m_last    = 1;
            m_data[0] = '0;
            m_data[1] = '0;
            mem_q.delete();
            resp_q.delete();
            return;
        end
        if (m_busy) begin
            if (bus.mem_ready_i) begin
                served         = m_owner;
                m_busy         = 1'b0;
                m_last         = served;
                m_pend[served] = 1'b0;
                if (!(served == 1 && m_we[1])) m_data[served] = bus.mem_data_i;
                resp_q.push_back('{port: served, cyc: cyc});
            end
        end else if (m_pend[0] || m_pend[1]) begin
            if (m_pend[0] && m_pend[1]) pick = 1 - m_last;
            else                        pick = m_pend[0] ? 0 : 1;
            m_owner = pick;
            m_busy  = 1'b1;
            mem_q.push_back('{port: pick, addr: m_addr[pick], we: m_we[pick], wdata: m_wdata[pick]});
        end
        if (bus.ic_req_i && !m_pend[0]) begin
            m_pend[0]  = 1'b1;
            m_addr[0]  = bus.ic_addr_i;
            m_we[0]    = 1'b0;
            m_wdata[0] = '0;
        end
        if (bus.dc_req_i && !m_pend[1]) begin
            m_pend[1]  = 1'b1;
            m_addr[1]  = bus.dc_addr_i;
            m_we[1]    = bus.dc_we_i;
            m_wdata[1] = bus.dc_wdata_i;
        end
    endtask

    task automatic checkOutput();
        logic [1:0] exp_rdy;
        resp_t      r;
        txn_t       t;
        exp_rdy = 2'b00;
        if (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
            r       = resp_q.pop_front();
            exp_rdy = (r.port == 0) ? 2'b10 : 2'b01;
        end
        check("ready_pulse {ic,dc}", line_t'({bus.ic_ready_o, bus.dc_ready_o}), line_t'(exp_rdy));
        check("ic_data_o", bus.ic_data_o, m_data[0]);
        check("dc_data_o", bus.dc_data_o, m_data[1]);
        check("mem_req_o", line_t'(bus.mem_req_o), line_t'(m_busy));
        if (bus.mem_req_o && !prev_req) begin
            n_txn++;
            if (mem_q.size() == 0) begin
                check("unexpected mem transaction", line_t'(bus.mem_req_o), line_t'(1'b0));
            end else begin
                t = mem_q.pop_front();
                check("mem_addr_o", line_t'(bus.mem_addr_o), line_t'(t.addr));
                check("mem_we_o", line_t'(bus.mem_we_o), line_t'(t.we));
                if (t.we) check("mem_wdata_o", bus.mem_wdata_o, t.wdata);
            end
        end
        prev_req = bus.mem_req_o;
    endtask

    always @(posedge clk) modelStep();
    always @(negedge clk) checkOutput();

    task automatic applyStimulus(input bit ic, input addr_t ic_a, input bit dc, input bit we,
                                 input addr_t dc_a, input line_t wd);
        @(negedge clk);
        bus.ic_req_i   = ic;
        bus.ic_addr_i  = ic_a;
        bus.dc_req_i   = dc;
        bus.dc_we_i    = we;
        bus.dc_addr_i  = dc_a;
        bus.dc_wdata_i = wd;
        @(negedge clk);
        bus.ic_req_i = 1'b0;
        bus.dc_req_i = 1'b0;
    endtask

    task automatic waitMemReq();
        int n;
        n = 0;
        while (!bus.mem_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mem_req_o) check("mem_req_o timeout", line_t'(bus.mem_req_o), line_t'(1'b1));
    endtask

    task automatic memRespond(input int delay, input line_t data);
        waitMemReq();
        repeat (delay) @(negedge clk);
        bus.mem_ready_i = 1'b1;
        bus.mem_data_i  = data;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        bus.mem_data_i  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic line_t rndLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    t0;
        line_t saved;
        bus.ic_req_i    = 1'b0;
        bus.ic_addr_i   = '0;
        bus.dc_req_i    = 1'b0;
        bus.dc_we_i     = 1'b0;
        bus.dc_addr_i   = '0;
        bus.dc_wdata_i  = '0;
        bus.mem_ready_i = 1'b0;
        bus.mem_data_i  = '0;
        repeat (3) @(negedge clk);
        check("reset mem_addr_o", line_t'(bus.mem_addr_o), '0);
        check("reset mem_we_o", line_t'(bus.mem_we_o), '0);
        check("reset mem_wdata_o", bus.mem_wdata_o, '0);
        rst = 1'b0;

        $display("[TB] single ICache read");
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, '0, '0);
        memRespond(3, 128'h1111_0000_1111_0000_1011_0000_1111_0000);
        repeat (2) @(negedge clk);
        check("single read ic_data_o", bus.ic_data_o, 128'h1111_0000_1111_0000_1011_0000_1111_0000);

        $display("[TB] simultaneous requests, round-robin");
        for (int rep = 0; rep < 3; rep++) begin
            applyStimulus(1'b1, 32'h21, 1'b1, 1'b0, 32'h40, '0);
            memRespond(1, rndLine());
            memRespond(2, rndLine());
            repeat (3) @(negedge clk);
        end

        $display("[TB] DCache write");
        saved = m_data[1];
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h80, {32{4'hA}});
        memRespond(1, rndLine());
        repeat (2) @(negedge clk);
        check("write keeps dc_data_o", bus.dc_data_o, saved);

        $display("[TB] reset while busy");
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0);
        waitMemReq();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mem_req_o after reset", line_t'(bus.mem_req_o), '0);
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] stray mem_ready and repeated request");
        t0 = n_txn;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, '0, '0);
        memRespond(2, rndLine());
        repeat (4) @(negedge clk);
        check("single transaction count", line_t'(n_txn - t0), line_t'(1));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst             = ($urandom_range(0, 149) == 0);
            bus.ic_req_i    = ($urandom_range(0, 3) == 0);
            bus.ic_addr_i   = $urandom;
            bus.dc_req_i    = ($urandom_range(0, 3) == 0);
            bus.dc_we_i     = $urandom_range(0, 1) == 1;
            bus.dc_addr_i   = $urandom;
            bus.dc_wdata_i  = rndLine();
            bus.mem_ready_i = ($urandom_range(0, 2) == 0);
            bus.mem_data_i  = rndLine();
        end

        @(negedge clk);
        rst          = 1'b0;
        bus.ic_req_i = 1'b0;
        bus.dc_req_i = 1'b0;
        for (int i = 0; i < 40 && (m_busy || m_pend[0] || m_pend[1]); i++) begin
            bus.mem_ready_i = 1'b1;
            bus.mem_data_i  = rndLine();
            @(negedge clk);
        end
        bus.mem_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("drain mem queue empty", line_t'(mem_q.size()), '0);
        check("drain resp queue empty", line_t'(resp_q.size()), '0);
        check("drain mem_req_o low", line_t'(bus.mem_req_o), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
